// File: rtl/sdc_cmd_seq.sv
// SD card SPI-mode command sequencer: frames one SD command, polls for R1,
// optionally collects a 4-byte R3/R7 trailer and releases chip select.
module sdc_cmd_seq #(
    parameter int POLL_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        resp_long,
    input  logic        keep_cs,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] resp_data,
    output logic        sdc_cs_n,
    output logic        spi_fast,
    output logic        spi_start,
    output logic [31:0] spi_tx,
    input  logic [31:0] spi_rx,
    input  logic        spi_rdy
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_POLL, S_LONG, S_END, S_FIN} state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_START, PH_WAIT} phase_t;

    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic        long_q, long_d, keep_q, keep_d;
    logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        cs_n_q, cs_n_d, spi_start_q, spi_start_d;
    logic [31:0] spi_tx_q, spi_tx_d;

    logic [7:0] cur_byte;
    logic       sending, xfer_done;
    logic [7:0] rx_byte;
    logic       rx_unused;

    assign rx_byte   = spi_rx[7:0];
    assign rx_unused = ^spi_rx[31:8];

    always_comb begin
        cur_byte = 8'hFF;
        if (state_q == S_CMD) begin
            case (byte_cnt_q)
                3'd0:    cur_byte = {2'b01, idx_q};
                3'd1:    cur_byte = arg_q[31:24];
                3'd2:    cur_byte = arg_q[23:16];
                3'd3:    cur_byte = arg_q[15:8];
                3'd4:    cur_byte = arg_q[7:0];
                default: cur_byte = {crc_q, 1'b1};
            endcase
        end
    end

    // END only moves a byte when chip select has been released (clock-out byte).
    assign sending   = (state_q == S_PRE) || (state_q == S_CMD) || (state_q == S_POLL) ||
                       (state_q == S_LONG) || ((state_q == S_END) && cs_n_q);
    assign xfer_done = sending && (phase_q == PH_WAIT) && spi_rdy;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        byte_cnt_d  = byte_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        crc_d       = crc_q;
        long_d      = long_q;
        keep_d      = keep_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        r1_d        = r1_q;
        resp_data_d = resp_data_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;

        // START is a dead cycle so the engine has dropped rdy before WAIT looks at it.
        if (sending) begin
            case (phase_q)
                PH_ISSUE: if (spi_rdy) begin
                    spi_start_d = 1'b1;
                    spi_tx_d    = {24'hFFFFFF, cur_byte};
                    phase_d     = PH_START;
                end
                PH_START: phase_d = PH_WAIT;
                default:  if (spi_rdy) phase_d = PH_ISSUE;
            endcase
        end

        case (state_q)
            S_IDLE, S_FIN: begin
                if (state_q == S_FIN) state_d = S_IDLE;
                if (cmd_start) begin
                    idx_d     = cmd_idx;
                    arg_d     = cmd_arg;
                    crc_d     = cmd_crc;
                    long_d    = resp_long;
                    keep_d    = keep_cs;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    phase_d   = PH_ISSUE;
                    state_d   = S_PRE;
                end
            end
            S_PRE: if (xfer_done) begin
                byte_cnt_d = 3'd0;
                state_d    = S_CMD;
            end
            S_CMD: if (xfer_done) begin
                if (byte_cnt_q == 3'd5) begin
                    poll_cnt_d = 8'd0;
                    state_d    = S_POLL;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end
            S_POLL: if (xfer_done) begin
                poll_cnt_d = poll_cnt_q + 8'd1;
                if (!rx_byte[7]) begin
                    r1_d = rx_byte;
                    if (long_q) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_LONG;
                    end else begin
                        cs_n_d  = !keep_q;
                        state_d = S_END;
                    end
                end else if (poll_cnt_q + 8'd1 == POLL_LAST) begin
                    r1_d      = 8'hFF;
                    timeout_d = 1'b1;
                    cs_n_d    = 1'b1;
                    state_d   = S_END;
                end
            end
            S_LONG: if (xfer_done) begin
                resp_data_d = {resp_data_q[23:0], rx_byte};
                if (byte_cnt_q == 3'd3) begin
                    cs_n_d  = !keep_q;
                    state_d = S_END;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end
            S_END: if (!cs_n_q || xfer_done) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            byte_cnt_q  <= 3'd0;
            poll_cnt_q  <= 8'd0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            crc_q       <= 7'd0;
            long_q      <= 1'b0;
            keep_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            r1_q        <= 8'hFF;
            resp_data_q <= 32'd0;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 32'hFFFFFFFF;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            byte_cnt_q  <= byte_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            crc_q       <= crc_d;
            long_q      <= long_d;
            keep_q      <= keep_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            r1_q        <= r1_d;
            resp_data_q <= resp_data_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign r1        = r1_q;
    assign resp_data = resp_data_q;
    assign sdc_cs_n  = cs_n_q;
    assign spi_fast  = 1'b0;
    assign spi_start = spi_start_q;
    assign spi_tx    = spi_tx_q;
endmodule

// File: tb/tb_sdc_cmd_seq.sv
// Directed bench for sdc_cmd_seq with a behavioural SPI byte engine that logs MOSI bytes.
module tb_sdc_cmd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic        resp_long = 1'b0;
    logic        keep_cs = 1'b0;
    logic        busy, done, timeout, sdc_cs_n, spi_fast, spi_start;
    logic [7:0]  r1;
    logic [31:0] resp_data, spi_tx;
    logic [31:0] spi_rx = 32'hFFFFFFFF;
    logic        spi_rdy = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdc_cmd_seq #(.POLL_MAX(8)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_idx(cmd_idx),
        .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .resp_long(resp_long), .keep_cs(keep_cs),
        .busy(busy), .done(done), .timeout(timeout), .r1(r1), .resp_data(resp_data),
        .sdc_cs_n(sdc_cs_n), .spi_fast(spi_fast), .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_rx(spi_rx), .spi_rdy(spi_rdy)
    );

    // Behavioural SPI engine: rdy drops after an accepted start, returns after 3+stall cycles.
    logic [7:0] tx_log [0:255];
    logic       cs_log [0:255];
    logic [7:0] resp_mem [0:255];
    int xfer = 0, cur = 0, lat = 0, stall = 0, viol = 0, hi_bad = 0, done_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_rdy <= 1'b1;
            lat     <= 0;
        end else if (spi_start) begin
            if (!spi_rdy) begin
                viol <= viol + 1;
            end else begin
                tx_log[xfer & 255] <= spi_tx[7:0];
                cs_log[xfer & 255] <= sdc_cs_n;
                if (spi_tx[31:8] !== 24'hFFFFFF) hi_bad <= hi_bad + 1;
                cur     <= xfer & 255;
                xfer    <= xfer + 1;
                spi_rdy <= 1'b0;
                lat     <= 3 + stall;
            end
        end else if (!spi_rdy) begin
            if (lat <= 1) begin
                spi_rdy <= 1'b1;
                spi_rx  <= {24'hFFFFFF, resp_mem[cur]};
            end else begin
                lat <= lat - 1;
            end
        end
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                             input logic lng, input logic keep);
        @(negedge clk);
        cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; resp_long = lng; keep_cs = keep;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input int base, input int n_low);
        check({tag, "_nbytes"}, xfer - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_tx%0d", tag, i), {24'd0, tx_log[(base + i) & 255]}, {24'd0, exp_q[i]});
            check($sformatf("%s_cs%0d", tag, i), {31'd0, cs_log[(base + i) & 255]},
                  (i >= n_low) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int base, d0, n;
        for (int i = 0; i < 256; i++) resp_mem[i] = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_r1", {24'd0, r1}, 32'h000000FF);
        check("rst_resp", resp_data, 32'd0);
        check("rst_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        check("rst_start", {31'd0, spi_start}, 32'd0);
        check("rst_tx", spi_tx, 32'hFFFFFFFF);
        check("rst_fast", {31'd0, spi_fast}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0: R1=0x01 on the second poll
        base = xfer; d0 = done_cnt;
        resp_mem[(base + 8) & 255] = 8'h01;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0);
        wait_done("cmd0");
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("cmd0", base, 9);
        check("cmd0_r1", {24'd0, r1}, 32'h01);
        check("cmd0_timeout", {31'd0, timeout}, 32'd0);
        check("cmd0_ndone", done_cnt - d0, 32'd1);
        check("cmd0_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        check("cmd0_busy", {31'd0, busy}, 32'd0);
        $display("txn cmd0: bytes=%0d r1=%h timeout=%b", xfer - base, r1, timeout);

        // CMD8 with R7 trailer
        base = xfer; d0 = done_cnt;
        resp_mem[(base + 7) & 255]  = 8'h01;
        resp_mem[(base + 8) & 255]  = 8'h00;
        resp_mem[(base + 9) & 255]  = 8'h00;
        resp_mem[(base + 10) & 255] = 8'h01;
        resp_mem[(base + 11) & 255] = 8'hAA;
        start_cmd(6'd8, 32'h000001AA, 7'h43, 1'b1, 1'b0);
        wait_done("cmd8");
        exp_q = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("cmd8", base, 12);
        check("cmd8_r1", {24'd0, r1}, 32'h01);
        check("cmd8_resp", resp_data, 32'h000001AA);
        check("cmd8_ndone", done_cnt - d0, 32'd1);
        check("cmd8_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        $display("txn cmd8: bytes=%0d r1=%h resp=%h", xfer - base, r1, resp_data);

        // Timeout: card never answers
        base = xfer; d0 = done_cnt;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b1, 1'b1);
        wait_done("tmo");
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("tmo", base, 15);
        check("tmo_r1", {24'd0, r1}, 32'hFF);
        check("tmo_timeout", {31'd0, timeout}, 32'd1);
        check("tmo_ndone", done_cnt - d0, 32'd1);
        check("tmo_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        check("tmo_resp_kept", resp_data, 32'h000001AA);
        $display("txn timeout: bytes=%0d r1=%h timeout=%b", xfer - base, r1, timeout);

        // CMD17 with keep_cs: CS stays low, no trailer byte
        base = xfer; d0 = done_cnt;
        resp_mem[(base + 7) & 255] = 8'h00;
        start_cmd(6'd17, 32'd0, 7'h2A, 1'b0, 1'b1);
        wait_done("cmd17");
        exp_q = '{8'hFF, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hFF};
        check_bytes("cmd17", base, 8);
        check("cmd17_r1", {24'd0, r1}, 32'h00);
        check("cmd17_timeout", {31'd0, timeout}, 32'd0);
        check("cmd17_cs_n", {31'd0, sdc_cs_n}, 32'd0);
        check("cmd17_ndone", done_cnt - d0, 32'd1);
        $display("txn cmd17: bytes=%0d r1=%h cs_n=%b", xfer - base, r1, sdc_cs_n);

        // Asynchronous reset during CMD byte 3
        base = xfer; d0 = done_cnt;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0);
        n = 0;
        while (xfer < base + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("arst_reached_byte3", {31'd0, xfer >= base + 5}, 32'd1);
        check("arst_busy_before", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        check("arst_tx", spi_tx, 32'hFFFFFFFF);
        check("arst_r1", {24'd0, r1}, 32'hFF);
        check("arst_start", {31'd0, spi_start}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_done", done_cnt - d0, 32'd0);
        $display("txn reset_abort: bytes_before_reset=%0d", xfer - base);

        base = xfer; d0 = done_cnt;
        resp_mem[(base + 8) & 255] = 8'h01;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0);
        wait_done("rerun");
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("rerun", base, 9);
        check("rerun_r1", {24'd0, r1}, 32'h01);
        check("rerun_ndone", done_cnt - d0, 32'd1);
        $display("txn rerun: bytes=%0d r1=%h", xfer - base, r1);

        // Slow engine plus a cmd_start while busy
        base = xfer; d0 = done_cnt;
        resp_mem[(base + 8) & 255] = 8'h01;
        stall = 50;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_during_stall", {31'd0, busy}, 32'd1);
        check("no_start_during_stall", {31'd0, spi_start}, 32'd0);
        start_cmd(6'd5, 32'hDEADBEEF, 7'h11, 1'b1, 1'b1);
        wait_done("stall");
        stall = 0;
        exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_bytes("stall", base, 9);
        check("stall_ndone", done_cnt - d0, 32'd1);
        check("stall_cs_n", {31'd0, sdc_cs_n}, 32'd1);
        repeat (20) @(negedge clk);
        check("stall_no_extra", xfer - base, 32'd10);
        $display("txn stall: bytes=%0d r1=%h", xfer - base, r1);

        check("start_while_not_ready", viol, 32'd0);
        check("tx_upper_ff", hi_bad, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdc_cmd_seq.md
Name: sdc_cmd_seq

Overview:
- Command sequencer for the SD card SPI byte engine.
- Takes one SD command (index, argument, CRC) from the SD controller register front-end and drives the SPI engine's start/rdy handshake byte by byte. Sequence: lead-in filler, 6-byte command frame, R1 polling, optional 4-byte trailer (R3/R7), chip-select release.
- Owns sdc_cs_n; it is the sole requester of the SPI engine while busy.

Parameters:
- POLL_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 (valid range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle request; accepted only when busy=0
- cmd_idx  in  6  SD command index
- cmd_arg  in  32  command argument, sent MSB first
- cmd_crc  in  7  CRC7 for the frame
- resp_long  in  1  1: read 4 bytes after R1 (R3/R7)
- keep_cs  in  1  1: leave card selected after response (data phase follows)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence
- timeout  out  1  no R1 within POLL_MAX polls; sticky until next accepted cmd_start
- r1  out  8  captured R1 byte
- resp_data  out  32  trailer bytes, first byte in [31:24]
- sdc_cs_n  out  1  card chip select, active low
- spi_fast  out  1  tied 0 (byte mode)
- spi_start  out  1  one-cycle start to the SPI engine
- spi_tx  out  32  {24'hFFFFFF, byte}
- spi_rx  in  32  engine receive data; only [7:0] is used
- spi_rdy  in  1  engine idle / transfer complete

Behaviour:
- Reset is asynchronous. Reset values: state IDLE, busy=0, done=0, timeout=0, r1=8'hFF, resp_data=0, sdc_cs_n=1, spi_start=0, spi_tx=32'hFFFFFFFF.
- A reset mid-sequence aborts immediately and emits no done pulse. The SPI engine is reset by the same rst.
- Byte transfer primitive:
  - ISSUE: wait for spi_rdy=1, then drive spi_start=1 for exactly one cycle with spi_tx valid in that cycle.
  - WAIT: spi_rdy reads 0 in the first WAIT cycle. Completion is the first cycle with spi_rdy=1; spi_rx[7:0] is sampled in that cycle.
  - spi_start is never asserted in WAIT.
- States and transitions:
  - IDLE: busy=0. cmd_start → latch all cmd_* inputs and resp_long/keep_cs, clear timeout, busy=1, sdc_cs_n=0 → PRE. cmd_start while busy is ignored.
  - PRE: send 0xFF → CMD, byte counter=0.
  - CMD: send the bytes in this order: {2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc, 1'b1}. Counter runs 0..5; after byte 5 → POLL, poll counter=0.
  - POLL: send 0xFF and increment the poll counter.
    - rx[7]=0 → r1=rx → LONG if resp_long, else END.
    - rx[7]=1 and counter reaches POLL_MAX → r1=8'hFF, timeout=1 → END. LONG is skipped.
  - LONG: send 0xFF 4 times and shift in resp_data={resp_data[23:0], rx} → END.
  - END:
    - keep_cs=0 or timeout=1: sdc_cs_n=1, then send one 0xFF with CS high → FIN.
    - keep_cs=1 without timeout: → FIN directly, CS stays low.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Outputs r1, resp_data and timeout are stable from the done pulse until the next accepted cmd_start.
- sdc_cs_n is registered and changes only on state entry into PRE and END.
- A cmd_start with keep_cs=1 from a previous sequence is legal: CS is already low and PRE still sends 0xFF.
- Counters: byte counter 3 bits, poll counter 8 bits; neither wraps, because transitions occur at the terminal values.

Test Plan:
- CMD0: idx=0, arg=0, crc=7'h4A, model answers 0x01 on the 2nd poll → MOSI bytes FF 40 00 00 00 00 95 FF FF then FF with CS high; r1=0x01, timeout=0, exactly one done pulse, sdc_cs_n=1 afterwards.
- CMD8: resp_long=1, arg=32'h000001AA, crc=7'h43; model sends R1=0x01 then 00 00 01 AA → frame byte 6 is 0x87; resp_data=32'h000001AA, r1=0x01.
- Timeout: model always returns 0xFF, POLL_MAX=8 → exactly 8 poll bytes, r1=0xFF, timeout=1, CS released, done pulses once.
- keep_cs=1 with CMD17, R1=0x00 on the 1st poll → sdc_cs_n stays 0 after done, no trailer byte sent.
- rst asserted during CMD byte 3 → outputs take reset values asynchronously, no done pulse; the next cmd_start restarts cleanly from PRE.
- cmd_start pulsed while busy and spi_rdy held low for 50 extra cycles → request ignored, no spi_start until spi_rdy=1, never two spi_start pulses per byte.
